fifo_rd_stream: RTL and testbench
=================================

# fifo_rd_stream

Read-side drain engine for the asynchronous FIFO. It runs in the read clock domain next to the read-pointer/empty-flag logic and issues pops (`rinc`) whenever the FIFO is non-empty and it has buffer room. It captures the one-cycle-latency RAM read data into a 2-entry output buffer and presents it as a valid/ready stream. Sustained throughput is one word per `rclk` while the FIFO stays non-empty and the consumer holds `m_ready` high.

## Interface
Parameters:
- `DATA_WIDTH`, 8: FIFO word width.
- `CNT_WIDTH`, 16: width of the delivered-word counter.

Ports:
- `rclk`  in  1  read-domain clock; one clock, all logic on its rising edge.
- `rrst_n`  in  1  reset, asynchronous, active-low.
- `rempty`  in  1  FIFO empty flag from read pointer logic; registered in that logic.
- `rdata`  in  DATA_WIDTH  FIFO RAM read data; valid the cycle after an accepted pop.
- `rinc`  out  1  pop request; combinational, never asserted while `rempty`=1.
- `m_valid`  out  1  output word available.
- `m_data`  out  DATA_WIDTH  output word; head of buffer.
- `m_ready`  in  1  consumer accepts `m_data` this cycle.
- `delivered_cnt`  out  CNT_WIDTH  number of handshakes (`m_valid && m_ready`) since reset; wraps.

## Operation
- Pop accepted in cycle T means `rinc`=1 in T. This implies `rempty`=0 in T.
- `inflight` register: set at the edge ending T, cleared the following edge. `rdata` is sampled at the edge ending T+1.
- Buffer: 2-entry FIFO, occupancy FSM `EMPTY`/`ONE`/`TWO`.
  - Write: `inflight`=1.
  - Read: `deq` = `m_valid && m_ready`.
  - `EMPTY`: write → `ONE`.
  - `ONE`: write only → `TWO`; deq only → `EMPTY`; both → `ONE`.
  - `TWO`: deq → `ONE`. Write while in `TWO` without deq is impossible by the credit rule; flag it with an assertion only.
- Credit rule: `rinc` = !`rempty` && (occ + `inflight` − `deq` < 2). `rinc` is combinational from `m_ready`.
- `m_valid` = (occ != `EMPTY`). `m_data` = head entry, held stable while `m_valid` && !`m_ready`.
- `delivered_cnt` increments by 1 on each `deq`. Width is CNT_WIDTH, so 2^CNT_WIDTH−1 +1 → 0.

## Timing
- Reset (async assert, sync-safe release):
  - `rinc`=0, `m_valid`=0, `m_data`=0, `delivered_cnt`=0.
  - Occupancy = `EMPTY`, `inflight`=0, buffer contents=0.
- Latency: `rempty` falls in cycle T, so the pop is in T and `m_valid`=1 from T+2 with `m_data` = that word.
- Back-to-back: with `m_ready`=1 and `rempty`=0, one `deq` per cycle in steady state (occ `ONE` + 1 in flight).
- Backpressure: after `m_ready` drops, at most 2 words are held. `rinc` stays 0 until a `deq` frees a slot; no word is dropped or duplicated.
- Pop and deq in the same cycle are legal, and the credit accounts for it.
- `rempty` rising mid-stream: no further pops; buffered and in-flight words still drain in order.
- Reset asserted mid-operation: all state cleared immediately. An in-flight word is discarded, and the upstream pointer resets too.

## Structure
- Shared package `fifo_pkg`: `occ_t` enum (`EMPTY`, `ONE`, `TWO`) and the default `DATA_WIDTH` constant shared with the read/write control blocks.
- One natural sub-module, `stream_buf2`, holding the 2-entry buffer and occupancy FSM, with ports `wr_en`/`wr_data`/`rd_en`/`occ`/`head`. The top level keeps the credit logic, `inflight`, and the counter.

## Test plan
- Reset:
  - Drive `rrst_n`=0 with `rempty`=0 → `rinc`=0, `m_valid`=0, `delivered_cnt`=0.
  - Release → first `rinc`=1 the next cycle.
- Single word:
  - FIFO holds 0xA5; `rempty` falls in cycle 10, `m_ready`=1.
  - Required: `rinc`=1 in cycle 10 only; `m_valid`=1 with 0xA5 in cycle 12; `delivered_cnt`=1 in cycle 13.
- Streaming: 8 words 0x01..0x08 with `m_ready`=1 → eight consecutive cycles of `m_valid`, data in order, `delivered_cnt`=8.
- Backpressure:
  - Stream 0x10..0x15 with `m_ready`=0 for cycles 3–9.
  - Required: `rinc` pulses exactly twice before the stall saturates, then stays 0; `m_data`=0x10 is held stable.
  - After release, all 6 words arrive in order with no gaps beyond one refill cycle.
- Empty mid-stream: `rempty` rises after 3 words → exactly 3 delivered, `m_valid` returns to 0, no `rinc` while `rempty`=1.
- Counter wrap and reset:
  - With CNT_WIDTH=4, deliver 17 words → `delivered_cnt`=1.
  - Assert `rrst_n`=0 with occ=`TWO` → all outputs are at reset values in the same cycle.

Source files
------------

// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_pkg
// Purpose  : Types and constants shared by the asynchronous FIFO read/write
//            control blocks.
// Contents : occ_t     - occupancy state of the 2-entry output buffer
//            c_DATA_WIDTH - default FIFO word width
//            occ_count - occupancy state to word count
// Revision : 1.0 - initial release
// ============================================================================
package fifo_pkg;

  localparam int c_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_t;

  function automatic logic [1:0] occ_count(input occ_t occ);
    case (occ)
      EMPTY:   occ_count = 2'd0;
      ONE:     occ_count = 2'd1;
      TWO:     occ_count = 2'd2;
      default: occ_count = 2'd0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/stream_buf2.sv
`default_nettype none
// ============================================================================
// Module   : stream_buf2
// Purpose  : Two-entry first-in/first-out holding buffer with an explicit
//            occupancy state machine.
// Ports    : rclk    - clock, rising edge
//            rrst_n  - asynchronous active-low reset
//            wr_en   - push wr_data this cycle
//            wr_data - word to push
//            rd_en   - pop the head entry this cycle
//            occ     - current occupancy (EMPTY / ONE / TWO)
//            head    - oldest stored word
// Revision : 1.0 - initial release
// ============================================================================
module stream_buf2
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = c_DATA_WIDTH
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output occ_t                  occ,
  output logic [DATA_WIDTH-1:0] head
);

  occ_t                  r_occ;
  logic [DATA_WIDTH-1:0] r_head;
  logic [DATA_WIDTH-1:0] r_tail;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_occ  <= EMPTY;
      r_head <= '0;
      r_tail <= '0;
    end else begin
      case (r_occ)
        EMPTY: begin
          if (wr_en) begin
            r_head <= wr_data;
            r_occ  <= ONE;
          end
        end
        ONE: begin
          if (wr_en && rd_en) begin
            // Head leaves while the new word arrives: it becomes the head.
            r_head <= wr_data;
          end else if (wr_en) begin
            r_tail <= wr_data;
            r_occ  <= TWO;
          end else if (rd_en) begin
            r_occ  <= EMPTY;
          end
        end
        TWO: begin
          if (rd_en) begin
            r_head <= r_tail;
            if (wr_en) begin
              r_tail <= wr_data;
            end else begin
              r_occ  <= ONE;
            end
          end
        end
        default: r_occ <= EMPTY;
      endcase
    end
  end

  assign occ  = r_occ;
  assign head = r_head;

  // The upstream credit scheme never lets a word land on a full buffer.
  a_no_overflow : assert property (@(posedge rclk) disable iff (!rrst_n)
    !(wr_en && !rd_en && (r_occ == TWO)));

endmodule
`default_nettype wire

// File: rtl/fifo_rd_stream.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rd_stream
// Purpose  : Read-side drain engine of the asynchronous FIFO. Pops words
//            while the FIFO is non-empty and buffer credit remains, captures
//            the one-cycle-latency RAM data into a 2-entry buffer and
//            presents it as a valid/ready stream.
// Ports    : rclk          - read-domain clock
//            rrst_n        - asynchronous active-low reset
//            rempty        - FIFO empty flag
//            rdata         - RAM read data, valid the cycle after a pop
//            rinc          - pop request (combinational)
//            m_valid       - output word available
//            m_data        - output word (buffer head)
//            m_ready       - consumer accepts m_data
//            delivered_cnt - handshakes since reset, wrapping
// Revision : 1.0 - initial release
// ============================================================================
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = c_DATA_WIDTH,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic                  rempty,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  rinc,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  delivered_cnt
);

  localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic                  r_run;
  logic                  r_inflight;
  logic [CNT_WIDTH-1:0]  r_cnt;
  occ_t                  w_occ;
  logic [DATA_WIDTH-1:0] w_head;
  logic                  w_deq;
  logic [2:0]            w_level;

  stream_buf2 #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .rclk    (rclk),
    .rrst_n  (rrst_n),
    .wr_en   (r_inflight),
    .wr_data (rdata),
    .rd_en   (w_deq),
    .occ     (w_occ),
    .head    (w_head)
  );

  assign m_valid = (w_occ != EMPTY);
  assign m_data  = w_head;
  assign w_deq   = m_valid && m_ready;

  // Words committed to the buffer: stored plus the one still in the RAM pipe.
  assign w_level = {1'b0, occ_count(w_occ)} + {2'b00, r_inflight};

  // Credit: level - deq < 2, rearranged to stay unsigned. r_run holds pops
  // off until the first edge after reset release.
  assign rinc = r_run && !rempty && (w_level < (3'd2 + {2'b00, w_deq}));

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_run      <= 1'b0;
      r_inflight <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_run      <= 1'b1;
      r_inflight <= rinc;
      if (w_deq) begin
        r_cnt <= r_cnt + c_CNT_ONE;
      end
    end
  end

  assign delivered_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_rd_stream
// Purpose  : Directed self-checking bench for fifo_rd_stream with a small
//            upstream FIFO model (word memory, pointers, registered data).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_stream;

  localparam int DW = 8;
  localparam int CW = 4;

  logic          rclk = 1'b0;
  logic          rrst_n;
  logic          rempty;
  logic [DW-1:0] rdata;
  logic          rinc;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready;
  logic [CW-1:0] delivered_cnt;

  logic [DW-1:0] mem [0:63];
  int            wr_ptr;
  int            rd_ptr;
  logic          hold_empty;

  int n_cmp = 0;
  int n_bad = 0;

  fifo_rd_stream #(
    .DATA_WIDTH (DW),
    .CNT_WIDTH  (CW)
  ) dut (
    .rclk          (rclk),
    .rrst_n        (rrst_n),
    .rempty        (rempty),
    .rdata         (rdata),
    .rinc          (rinc),
    .m_valid       (m_valid),
    .m_data        (m_data),
    .m_ready       (m_ready),
    .delivered_cnt (delivered_cnt)
  );

  always #5 rclk = ~rclk;

  // Upstream FIFO model: data appears the cycle after a pop.
  assign rempty = hold_empty || (wr_ptr == rd_ptr);

  always @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rd_ptr <= 0;
      rdata  <= '0;
    end else if (rinc) begin
      rdata  <= mem[rd_ptr];
      rd_ptr <= rd_ptr + 1;
    end
  end

  task automatic do_reset();
    @(negedge rclk);
    rrst_n     = 1'b0;
    hold_empty = 1'b0;
    m_ready    = 1'b0;
    wr_ptr     = 0;
    repeat (2) @(negedge rclk);
    rrst_n = 1'b1;
    @(negedge rclk);
  endtask

  task automatic load(input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) begin
      mem[wr_ptr + i] = base + DW'(i);
    end
    wr_ptr = wr_ptr + n;
  endtask

  task automatic test_reset();
    @(negedge rclk);
    rrst_n     = 1'b0;
    m_ready    = 1'b0;
    hold_empty = 1'b0;
    mem[0]     = 8'h5A;
    wr_ptr     = 1;
    #1;
    n_cmp++; if (rinc !== 1'b0) begin n_bad++; $display("FAIL reset_rinc: got %b want 0", rinc); end
    n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
    n_cmp++; if (m_data !== 8'h00) begin n_bad++; $display("FAIL reset_m_data: got %0h want 0", m_data); end
    n_cmp++; if (delivered_cnt !== 4'd0) begin n_bad++; $display("FAIL reset_cnt: got %0d want 0", delivered_cnt); end
    @(negedge rclk);
    rrst_n = 1'b1;
    #1;
    n_cmp++; if (rinc !== 1'b0) begin n_bad++; $display("FAIL release_rinc0: got %b want 0", rinc); end
    @(negedge rclk);
    #1;
    n_cmp++; if (rinc !== 1'b1) begin n_bad++; $display("FAIL release_rinc1: got %b want 1", rinc); end
  endtask

  task automatic test_single();
    do_reset();
    m_ready = 1'b1;
    load(1, 8'hA5);
    #1;
    n_cmp++; if (rinc !== 1'b1) begin n_bad++; $display("FAIL single_pop: got %b want 1", rinc); end
    @(negedge rclk); #1;
    n_cmp++; if (rinc !== 1'b0) begin n_bad++; $display("FAIL single_nopop: got %b want 0", rinc); end
    n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL single_early_valid: got %b want 0", m_valid); end
    @(negedge rclk); #1;
    n_cmp++; if (m_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid: got %b want 1", m_valid); end
    n_cmp++; if (m_data !== 8'hA5) begin n_bad++; $display("FAIL single_data: got %0h want a5", m_data); end
    n_cmp++; if (delivered_cnt !== 4'd0) begin n_bad++; $display("FAIL single_cnt0: got %0d want 0", delivered_cnt); end
    @(negedge rclk); #1;
    n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL single_valid_drop: got %b want 0", m_valid); end
    n_cmp++; if (delivered_cnt !== 4'd1) begin n_bad++; $display("FAIL single_cnt1: got %0d want 1", delivered_cnt); end
  endtask

  task automatic test_streaming();
    int got, first, last;
    got = 0; first = -1; last = -1;
    do_reset();
    load(8, 8'h01);
    m_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (m_valid && m_ready) begin
        n_cmp++;
        if (m_data !== DW'(got + 1)) begin
          n_bad++; $display("FAIL stream_data[%0d]: got %0h want %0h", got, m_data, got + 1);
        end
        if (first < 0) first = c;
        last = c;
        got++;
      end
      @(negedge rclk);
    end
    n_cmp++; if (got != 8) begin n_bad++; $display("FAIL stream_count: got %0d want 8", got); end
    n_cmp++; if (first != 2) begin n_bad++; $display("FAIL stream_latency: got %0d want 2", first); end
    n_cmp++; if (last - first != 7) begin n_bad++; $display("FAIL stream_span: got %0d want 7", last - first); end
    n_cmp++; if (delivered_cnt !== 4'd8) begin n_bad++; $display("FAIL stream_cnt: got %0d want 8", delivered_cnt); end
  endtask

  task automatic test_backpressure();
    int pulses, got, first, last;
    pulses = 0; got = 0; first = -1; last = -1;
    do_reset();
    load(6, 8'h10);
    m_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (rinc) pulses++;
      if (c >= 2) begin
        n_cmp++;
        if (m_valid !== 1'b1 || m_data !== 8'h10) begin
          n_bad++; $display("FAIL bp_hold[c%0d]: got v=%b d=%0h want v=1 d=10", c, m_valid, m_data);
        end
      end
      @(negedge rclk);
    end
    n_cmp++; if (pulses != 2) begin n_bad++; $display("FAIL bp_pulses: got %0d want 2", pulses); end
    m_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (m_valid) begin
        n_cmp++;
        if (m_data !== 8'h10 + DW'(got)) begin
          n_bad++; $display("FAIL bp_data[%0d]: got %0h want %0h", got, m_data, 8'h10 + got);
        end
        if (first < 0) first = c;
        last = c;
        got++;
      end
      @(negedge rclk);
    end
    n_cmp++; if (got != 6) begin n_bad++; $display("FAIL bp_count: got %0d want 6", got); end
    n_cmp++; if (last - first > 6) begin n_bad++; $display("FAIL bp_gap: got span %0d want <=6", last - first); end
    n_cmp++; if (delivered_cnt !== 4'd6) begin n_bad++; $display("FAIL bp_cnt: got %0d want 6", delivered_cnt); end
  endtask

  task automatic test_empty_midstream();
    int got;
    got = 0;
    do_reset();
    load(6, 8'h20);
    m_ready = 1'b1;
    for (int c = 0; c < 15; c++) begin
      if (c == 3) hold_empty = 1'b1;
      #1;
      if (rempty) begin
        n_cmp++;
        if (rinc !== 1'b0) begin n_bad++; $display("FAIL empty_rinc[c%0d]: got %b want 0", c, rinc); end
      end
      if (m_valid) begin
        n_cmp++;
        if (m_data !== 8'h20 + DW'(got)) begin
          n_bad++; $display("FAIL empty_data[%0d]: got %0h want %0h", got, m_data, 8'h20 + got);
        end
        got++;
      end
      @(negedge rclk);
    end
    #1;
    n_cmp++; if (got != 3) begin n_bad++; $display("FAIL empty_count: got %0d want 3", got); end
    n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL empty_valid: got %b want 0", m_valid); end
    n_cmp++; if (delivered_cnt !== 4'd3) begin n_bad++; $display("FAIL empty_cnt: got %0d want 3", delivered_cnt); end
    hold_empty = 1'b0;
  endtask

  task automatic test_counter_wrap();
    do_reset();
    load(17, 8'h40);
    m_ready = 1'b1;
    repeat (25) @(negedge rclk);
    #1;
    n_cmp++; if (delivered_cnt !== 4'd1) begin n_bad++; $display("FAIL wrap_cnt: got %0d want 1", delivered_cnt); end
    n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL wrap_drained: got %b want 0", m_valid); end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    load(5, 8'h60);
    m_ready = 1'b1;
    repeat (3) @(negedge rclk);
    m_ready = 1'b0;
    @(negedge rclk); #1;
    n_cmp++; if (m_valid !== 1'b1 || m_data !== 8'h61) begin
      n_bad++; $display("FAIL mid_full: got v=%b d=%0h want v=1 d=61", m_valid, m_data);
    end
    n_cmp++; if (rinc !== 1'b0) begin n_bad++; $display("FAIL mid_full_rinc: got %b want 0", rinc); end
    n_cmp++; if (delivered_cnt !== 4'd1) begin n_bad++; $display("FAIL mid_cnt: got %0d want 1", delivered_cnt); end
    @(negedge rclk);
    rrst_n = 1'b0;
    #1;
    n_cmp++; if (rinc !== 1'b0) begin n_bad++; $display("FAIL mid_rst_rinc: got %b want 0", rinc); end
    n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_valid: got %b want 0", m_valid); end
    n_cmp++; if (m_data !== 8'h00) begin n_bad++; $display("FAIL mid_rst_data: got %0h want 0", m_data); end
    n_cmp++; if (delivered_cnt !== 4'd0) begin n_bad++; $display("FAIL mid_rst_cnt: got %0d want 0", delivered_cnt); end
    @(negedge rclk);
    rrst_n = 1'b1;
  endtask

  initial begin
    rrst_n     = 1'b0;
    m_ready    = 1'b0;
    hold_empty = 1'b1;
    wr_ptr     = 0;
    test_reset();
    test_single();
    test_streaming();
    test_backpressure();
    test_empty_midstream();
    test_counter_wrap();
    test_reset_midstream();
    repeat (2) @(negedge rclk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
